pixel_stream_writer: RTL and testbench



---
 rtl/pixel_stream_writer.sv | 156 +++++++++++++++
 tb/tb_pixel_stream_writer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_writer.sv
// Avalon-ST video sink: parses the video packet header and writes pixel N of
// one frame to pixel buffer word N through an Avalon-MM write master port.
module pixel_stream_writer #(
    parameter int FRAME_PIXELS = 153600,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    input  logic              snk_startofpacket,
    input  logic              snk_endofpacket,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] buf_address,
    output logic              buf_chipselect,
    output logic              buf_write,
    output logic [DATA_W-1:0] buf_writedata,
    output logic              frame_done,
    output logic              err_short,
    output logic              err_long,
    output logic              busy,
    output logic [15:0]       frame_count
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOP,
        SKIP,
        CAPTURE,
        DRAIN
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [ADDR_W:0]   cnt_inc;
    logic              overflow, overflow_nxt;
    logic              wr_nxt, done_nxt, short_nxt, long_nxt;
    logic              accept, hdr_video, at_last, decode_hdr;

    assign accept    = snk_valid & snk_ready;
    assign hdr_video = (snk_data[3:0] == 4'd0);
    // One extra bit so cnt+1 == FRAME_PIXELS is exact even when the frame fills the address space.
    assign cnt_inc   = {1'b0, cnt} + (ADDR_W+1)'(1);
    assign at_last   = (cnt_inc == (ADDR_W+1)'(FRAME_PIXELS));

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_nxt    = state;
        cnt_nxt      = cnt;
        overflow_nxt = overflow;
        wr_nxt       = 1'b0;
        done_nxt     = 1'b0;
        short_nxt    = 1'b0;
        long_nxt     = 1'b0;
        decode_hdr   = 1'b0;

        case (state)
            IDLE: begin
                if (enable) state_nxt = WAIT_SOP;
            end
            WAIT_SOP: begin
                if (!enable) state_nxt = IDLE;
                else if (accept && snk_startofpacket) decode_hdr = 1'b1;
            end
            SKIP: begin
                if (accept && snk_endofpacket) state_nxt = WAIT_SOP;
            end
            CAPTURE: begin
                if (accept) begin
                    if (snk_startofpacket) begin
                        short_nxt  = 1'b1;
                        decode_hdr = 1'b1;
                    end else begin
                        wr_nxt  = 1'b1;
                        cnt_nxt = at_last ? cnt : cnt_inc[ADDR_W-1:0];
                        if (snk_endofpacket) begin
                            state_nxt = WAIT_SOP;
                            if (at_last) done_nxt  = 1'b1;
                            else         short_nxt = 1'b1;
                        end else if (at_last) begin
                            state_nxt    = DRAIN;
                            overflow_nxt = 1'b0;
                        end
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    if (snk_startofpacket) begin
                        // A full frame cut off by a new header still counts as complete.
                        done_nxt   = 1'b1;
                        decode_hdr = 1'b1;
                    end else if (snk_endofpacket) begin
                        state_nxt = WAIT_SOP;
                        if (overflow) long_nxt = 1'b1;
                        else          done_nxt = 1'b1;
                    end else begin
                        overflow_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (decode_hdr) begin
            if (hdr_video && !snk_endofpacket) begin
                state_nxt    = CAPTURE;
                cnt_nxt      = '0;
                overflow_nxt = 1'b0;
            end else if (!hdr_video && !snk_endofpacket) begin
                state_nxt = SKIP;
            end else begin
                state_nxt = WAIT_SOP;
                if (hdr_video) short_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            overflow       <= 1'b0;
            snk_ready      <= 1'b0;
            busy           <= 1'b0;
            buf_address    <= '0;
            buf_writedata  <= '0;
            buf_write      <= 1'b0;
            buf_chipselect <= 1'b0;
            frame_done     <= 1'b0;
            err_short      <= 1'b0;
            err_long       <= 1'b0;
            frame_count    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            overflow       <= overflow_nxt;
            snk_ready      <= (state_nxt != IDLE);
            busy           <= (state_nxt == CAPTURE) || (state_nxt == DRAIN);
            buf_write      <= wr_nxt;
            buf_chipselect <= wr_nxt;
            if (wr_nxt) begin
                buf_address   <= cnt;
                buf_writedata <= snk_data;
            end
            frame_done     <= done_nxt;
            err_short      <= short_nxt;
            err_long       <= long_nxt;
            if (done_nxt) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Directed bench for pixel_stream_writer, built with a reduced frame size so
// full, short, long, premature and gapped frames all fit in a short run.
module tb_pixel_stream_writer;

    localparam int FP = 300;
    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] snk_data = '0;
    logic          snk_valid = 1'b0;
    logic          snk_startofpacket = 1'b0;
    logic          snk_endofpacket = 1'b0;
    logic          snk_ready;
    logic [AW-1:0] buf_address;
    logic          buf_chipselect;
    logic          buf_write;
    logic [DW-1:0] buf_writedata;
    logic          frame_done;
    logic          err_short;
    logic          err_long;
    logic          busy;
    logic [15:0]   frame_count;

    int compared = 0;
    int mismatched = 0;

    logic pix_flag = 1'b0;
    logic ready_watch = 1'b0;
    logic exp_wr = 1'b0;
    int   acc_n = 0, done_n = 0, short_n = 0, long_n = 0;
    int   cs_bad = 0, lag_bad = 0, done_nowr = 0, ready_bad = 0;
    int   short_at_wr = -1;
    logic [AW-1:0] wlog_a[$];
    logic [DW-1:0] wlog_d[$];

    always #5 clk = ~clk;

    pixel_stream_writer #(
        .FRAME_PIXELS(FP),
        .ADDR_W      (AW),
        .DATA_W      (DW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .snk_data         (snk_data),
        .snk_valid        (snk_valid),
        .snk_startofpacket(snk_startofpacket),
        .snk_endofpacket  (snk_endofpacket),
        .snk_ready        (snk_ready),
        .buf_address      (buf_address),
        .buf_chipselect   (buf_chipselect),
        .buf_write        (buf_write),
        .buf_writedata    (buf_writedata),
        .frame_done       (frame_done),
        .err_short        (err_short),
        .err_long         (err_long),
        .busy             (busy),
        .frame_count      (frame_count)
    );

    // Acceptance side: a pixel beat that should be stored is expected to show up as a write next cycle.
    always @(posedge clk) begin
        exp_wr <= snk_valid && snk_ready && pix_flag && !reset;
        if (snk_valid && snk_ready && !reset) acc_n++;
    end

    always @(negedge clk) begin
        if (buf_write === 1'b1) begin
            wlog_a.push_back(buf_address);
            wlog_d.push_back(buf_writedata);
        end
        if (buf_chipselect !== buf_write) cs_bad++;
        if (buf_write !== exp_wr) lag_bad++;
        if (frame_done === 1'b1) begin
            done_n++;
            if (buf_write !== 1'b1) done_nowr++;
        end
        if (err_short === 1'b1) begin
            short_n++;
            short_at_wr = wlog_a.size();
        end
        if (err_long === 1'b1) long_n++;
        if (ready_watch && snk_ready !== 1'b1) ready_bad++;
    end

    task automatic beat(input logic [DW-1:0] d, input logic sop, input logic eop, input logic pix);
        @(negedge clk);
        snk_valid         = 1'b1;
        snk_data          = d;
        snk_startofpacket = sop;
        snk_endofpacket   = eop;
        pix_flag          = pix;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            snk_valid         = 1'b0;
            snk_startofpacket = 1'b0;
            snk_endofpacket   = 1'b0;
            pix_flag          = 1'b0;
        end
    endtask

    task automatic send_video(input int n, input bit eop_last, input bit gaps);
        beat(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            beat(DW'(i), 1'b0, eop_last && (i == n - 1), i < FP);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        compared++;
        if ({snk_ready, buf_write, buf_chipselect, frame_done, err_short, err_long, busy} !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {snk_ready, buf_write, buf_chipselect, frame_done, err_short, err_long, busy});
        end
        compared++;
        if (buf_address !== '0 || buf_writedata !== '0) begin
            mismatched++;
            $display("FAIL reset_bus: addr %0h data %0h expected 0 0", buf_address, buf_writedata);
        end
        compared++;
        if (frame_count !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_frame_count: got %0d expected 0", frame_count);
        end
        reset = 1'b0;
        idle(2);
        compared++;
        if (snk_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_ready: got %b expected 0", snk_ready);
        end
    endtask

    task automatic test_arm;
        enable = 1'b1;
        idle(3);
        compared++;
        if (snk_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL arm: ready %b busy %b expected 1 0", snk_ready, busy);
        end
    endtask

    task automatic test_full_frame;
        int d0 = done_n, s0 = short_n, l0 = long_n, g0 = lag_bad, w0 = done_nowr, c0 = cs_bad;
        int bad = 0;
        wlog_a.delete();
        wlog_d.delete();
        beat(8'h0F, 1'b1, 1'b0, 1'b0);
        beat(8'h11, 1'b0, 1'b0, 1'b0);
        beat(8'h22, 1'b0, 1'b0, 1'b0);
        beat(8'h33, 1'b0, 1'b1, 1'b0);
        send_video(FP, 1'b1, 1'b0);
        idle(4);
        for (int i = 0; i < wlog_a.size(); i++)
            if (wlog_a[i] !== AW'(i) || wlog_d[i] !== DW'(i)) bad++;
        compared++;
        if (wlog_a.size() != FP) begin
            mismatched++;
            $display("FAIL full_writes: got %0d expected %0d", wlog_a.size(), FP);
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL full_sequence: %0d bad writes expected 0", bad);
        end
        compared++;
        if (done_n - d0 != 1 || short_n - s0 != 0 || long_n - l0 != 0) begin
            mismatched++;
            $display("FAIL full_pulses: done %0d short %0d long %0d expected 1 0 0",
                     done_n - d0, short_n - s0, long_n - l0);
        end
        compared++;
        if (done_nowr - w0 != 0) begin
            mismatched++;
            $display("FAIL full_done_with_write: %0d unaligned expected 0", done_nowr - w0);
        end
        compared++;
        if (frame_count !== 16'd1) begin
            mismatched++;
            $display("FAIL full_frame_count: got %0d expected 1", frame_count);
        end
        compared++;
        if (lag_bad - g0 != 0 || cs_bad - c0 != 0) begin
            mismatched++;
            $display("FAIL full_write_timing: lag %0d cs %0d expected 0 0", lag_bad - g0, cs_bad - c0);
        end
    endtask

    task automatic test_short_frame;
        int d0 = done_n, s0 = short_n;
        int bad = 0;
        wlog_a.delete();
        wlog_d.delete();
        send_video(100, 1'b1, 1'b0);
        idle(4);
        for (int i = 0; i < wlog_a.size(); i++)
            if (wlog_a[i] !== AW'(i) || wlog_d[i] !== DW'(i)) bad++;
        compared++;
        if (wlog_a.size() != 100 || bad != 0) begin
            mismatched++;
            $display("FAIL short_writes: got %0d (%0d bad) expected 100 (0 bad)", wlog_a.size(), bad);
        end
        compared++;
        if (short_n - s0 != 1 || done_n - d0 != 0) begin
            mismatched++;
            $display("FAIL short_pulses: short %0d done %0d expected 1 0", short_n - s0, done_n - d0);
        end
        compared++;
        if (frame_count !== 16'd1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL short_state: count %0d busy %b expected 1 0", frame_count, busy);
        end
    endtask

    task automatic test_long_frame;
        int d0 = done_n, s0 = short_n, l0 = long_n, g0 = lag_bad;
        int bad = 0;
        wlog_a.delete();
        wlog_d.delete();
        send_video(FP + 2, 1'b1, 1'b0);
        idle(4);
        for (int i = 0; i < wlog_a.size(); i++)
            if (wlog_a[i] !== AW'(i) || wlog_d[i] !== DW'(i)) bad++;
        compared++;
        if (wlog_a.size() != FP || bad != 0) begin
            mismatched++;
            $display("FAIL long_writes: got %0d (%0d bad) expected %0d (0 bad)", wlog_a.size(), bad, FP);
        end
        compared++;
        if (long_n - l0 != 1 || done_n - d0 != 0 || short_n - s0 != 0) begin
            mismatched++;
            $display("FAIL long_pulses: long %0d done %0d short %0d expected 1 0 0",
                     long_n - l0, done_n - d0, short_n - s0);
        end
        compared++;
        if (frame_count !== 16'd1 || lag_bad - g0 != 0) begin
            mismatched++;
            $display("FAIL long_state: count %0d lag %0d expected 1 0", frame_count, lag_bad - g0);
        end
    endtask

    task automatic test_premature_sop;
        int d0 = done_n, s0 = short_n;
        int bad = 0;
        wlog_a.delete();
        wlog_d.delete();
        send_video(10, 1'b0, 1'b0);
        send_video(FP, 1'b1, 1'b0);
        idle(4);
        for (int i = 0; i < wlog_a.size(); i++) begin
            int p = (i < 10) ? i : i - 10;
            if (wlog_a[i] !== AW'(p) || wlog_d[i] !== DW'(p)) bad++;
        end
        compared++;
        if (wlog_a.size() != FP + 10 || bad != 0) begin
            mismatched++;
            $display("FAIL premature_writes: got %0d (%0d bad) expected %0d (0 bad)",
                     wlog_a.size(), bad, FP + 10);
        end
        compared++;
        if (short_n - s0 != 1 || short_at_wr != 10) begin
            mismatched++;
            $display("FAIL premature_short: pulses %0d after write %0d expected 1 after 10",
                     short_n - s0, short_at_wr);
        end
        compared++;
        if (done_n - d0 != 1 || frame_count !== 16'd2) begin
            mismatched++;
            $display("FAIL premature_done: done %0d count %0d expected 1 2", done_n - d0, frame_count);
        end
    endtask

    task automatic test_back_to_back;
        int a0 = acc_n, g0 = lag_bad, r0 = ready_bad;
        int bad = 0;
        wlog_a.delete();
        wlog_d.delete();
        ready_watch = 1'b1;
        send_video(FP, 1'b1, 1'b1);
        idle(4);
        ready_watch = 1'b0;
        for (int i = 0; i < wlog_a.size(); i++)
            if (wlog_a[i] !== AW'(i) || wlog_d[i] !== DW'(i)) bad++;
        compared++;
        if (acc_n - a0 != FP + 1 || wlog_a.size() != FP || bad != 0) begin
            mismatched++;
            $display("FAIL flow_counts: accepted %0d writes %0d bad %0d expected %0d %0d 0",
                     acc_n - a0, wlog_a.size(), bad, FP + 1, FP);
        end
        compared++;
        if (lag_bad - g0 != 0 || ready_bad - r0 != 0) begin
            mismatched++;
            $display("FAIL flow_timing: lag %0d ready_low %0d expected 0 0", lag_bad - g0, ready_bad - r0);
        end
        compared++;
        if (frame_count !== 16'd3) begin
            mismatched++;
            $display("FAIL flow_frame_count: got %0d expected 3", frame_count);
        end
    endtask

    task automatic test_enable_low;
        int d0 = done_n;
        wlog_a.delete();
        wlog_d.delete();
        beat(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < FP; i++) begin
            if (i == 50) enable = 1'b0;
            beat(DW'(i), 1'b0, i == FP - 1, 1'b1);
            if (i == 60) begin
                compared++;
                if (busy !== 1'b1 || snk_ready !== 1'b1) begin
                    mismatched++;
                    $display("FAIL enable_mid: busy %b ready %b expected 1 1", busy, snk_ready);
                end
            end
        end
        idle(4);
        compared++;
        if (snk_ready !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL enable_idle: ready %b busy %b expected 0 0", snk_ready, busy);
        end
        compared++;
        if (done_n - d0 != 1 || frame_count !== 16'd4 || wlog_a.size() != FP) begin
            mismatched++;
            $display("FAIL enable_frame: done %0d count %0d writes %0d expected 1 4 %0d",
                     done_n - d0, frame_count, wlog_a.size(), FP);
        end
        enable = 1'b1;
        idle(3);
    endtask

    task automatic test_reset_mid_frame;
        int d0 = done_n, s0 = short_n, l0 = long_n;
        wlog_a.delete();
        wlog_d.delete();
        beat(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 150; i++) beat(DW'(i), 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset     = 1'b1;
        snk_valid = 1'b0;
        pix_flag  = 1'b0;
        @(negedge clk);
        compared++;
        if ({snk_ready, buf_write, buf_chipselect, frame_done, err_short, err_long, busy} !== 7'b0 ||
            buf_address !== '0 || buf_writedata !== '0 || frame_count !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_mid_outputs: flags %b addr %0h data %0h count %0d expected all 0",
                     {snk_ready, buf_write, buf_chipselect, frame_done, err_short, err_long, busy},
                     buf_address, buf_writedata, frame_count);
        end
        reset = 1'b0;
        idle(4);
        compared++;
        if (short_n - s0 != 0 || long_n - l0 != 0 || done_n - d0 != 0 || wlog_a.size() != 150) begin
            mismatched++;
            $display("FAIL reset_mid_pulses: short %0d long %0d done %0d writes %0d expected 0 0 0 150",
                     short_n - s0, long_n - l0, done_n - d0, wlog_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_full_frame();
        test_short_frame();
        test_long_frame();
        test_premature_sop();
        test_back_to_back();
        test_enable_low();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
